pipe_stage_slot: RTL and testbench
==================================

// Module: pipe_stage_slot
// PURPOSE
// - Parametrised successor of the fixed M->W stage register: one pipeline stage slot carrying NCH
//   channels of W bits (command, PC, DM out, ALU result, HI, LO, CP0 out, ...).
// - Adds a valid/ready handshake with an optional one-entry skid buffer and flush-to-bubble.
// - Flush can keep one channel (the PC) so the CP0/EPC logic still sees the bubble's address.
// - Instantiated between any two stages (F/D, D/E, E/M, M/W); replaces the per-stage hand-written registers.
// PARAMETERS
// - W        32  bits per channel
// - NCH      7   number of channels; in_data/out_data are NCH*W wide, channel k = [k*W +: W]
// - SKID     1   1: two-entry slot (main + skid), in_ready is registered; 0: single entry, in_ready is combinational
// - KEEP_CH  1   channel kept on flush (PC); a value >= NCH means no channel is kept
// PORTS
// - clk        in   1      clock, rising edge
// - res        in   1      reset, asynchronous, active-low
// - in_valid   in   1      upstream beat present
// - in_ready   out  1      slot accepts a beat this cycle
// - in_data    in   NCH*W  upstream channels
// - flush      in   1      synchronous flush: turn the slot into a bubble
// - out_valid  out  1      main entry holds a valid beat
// - out_ready  in   1      downstream consumes the beat this cycle
// - out_data   out  NCH*W  main entry channels
// - occ        out  2      occupancy 0..2 (diagnostic)
// BEHAVIOUR
// - Reset (res=0, takes effect without a clock edge): main and skid entries cleared to zero, state EMPTY,
//   out_valid=0, occ=0, out_data=0. in_ready=1 while SKID=1; while SKID=0 it follows the combinational rule below.
// - Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency is 1 cycle from
//   in_fire to out_valid. Throughput is 1 beat/cycle.
// - States (SKID=1): EMPTY (occ=0), ONE (occ=1), TWO (occ=2). out_valid = (state!=EMPTY); in_ready = (state!=TWO).
//   - EMPTY: in_fire -> ONE, main<=in_data.
//   - ONE: in_fire&out_fire -> ONE, main<=in_data. in_fire only -> TWO, skid<=in_data. out_fire only -> EMPTY.
//   - TWO: out_fire -> ONE, main<=skid; otherwise hold. No in_fire is possible in TWO.
// - SKID=0: states EMPTY/ONE only. in_ready = ~out_valid | out_ready. Simultaneous in/out fire -> ONE, main<=in_data.
// - Data ordering is strictly FIFO; no beat is lost or duplicated without a flush.
// - Holding: when no transition loads an entry, that entry keeps its value, including the data of a consumed
//   (now invalid) entry.
// - Flush (highest priority, overrides every transition):
//   - next state is EMPTY and the skid entry is cleared;
//   - every main channel is zeroed except KEEP_CH, which holds its current value;
//   - a beat that fires on in_fire in the flush cycle is consumed and dropped;
//   - out_fire in the flush cycle is still a valid consume (downstream already took it).
// - Asserting reset mid-transfer aborts immediately; the first cycle after reset release behaves as EMPTY.
// - Widths: no arithmetic on data. occ is a 2-bit count and never exceeds 2 (never exceeds 1 when SKID=0).
// STRUCTURE
// - Package pipe_pkg holds:
//   - channel index constants CH_CMD=0, CH_PC=1, CH_DM=2, CH_ALU=3, CH_HI=4, CH_LO=5, CH_CP0=6;
//   - state encoding ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
//   - default widths W and NCH.
// - One sub-module, pipe_entry: NCH*W register with load, clear and keep-channel masking. It is instantiated
//   twice (main, skid); the skid instance exists only under generate when SKID=1.
// - Top level contains the state register, fire logic, the main-load mux (in_data or skid), and the ready/valid/occ decode.
// TESTING
// - Reset: drive res=0 mid-cycle with data present -> out_valid=0, occ=0, out_data=0 immediately, with no clock edge.
// - Streaming: SKID=1, in_valid=1, out_ready=1, beats 0x100..0x10F -> the same 16 beats appear in order,
//   1 cycle later, in_ready held at 1.
// - Backpressure: SKID=1, out_ready=0, send 0xA, 0xB -> occ=2 and in_ready=0; a third beat 0xC is not accepted.
//   Raise out_ready -> output sequence 0xA, 0xB, 0xC with no gaps.
// - Flush with keep: main holds PC channel 0x00003000 and CMD channel 0x8C010004; pulse flush with in_fire
//   carrying 0xD -> next cycle out_valid=0, CMD=0, PC=0x00003000, occ=0, and beat 0xD never appears.
// - SKID=0: out_ready=0 with main full -> in_ready=0 combinationally. Set out_ready=1 in the same cycle as
//   in_valid=1 -> in_ready=1 and main is replaced by the new beat in one cycle.
// - Random: random in_valid/out_ready/flush run compared against a scoreboard queue -> order is preserved,
//   occ matches the queue depth, and no beat survives a flush.

Source files
------------

// File: rtl/pipe_stage_slot_pkg.sv
// Package pipe_pkg: shared constants for the pipeline stage slot.
//   - channel index constants for the M->W style payload
//   - state encoding of the slot (the encoding doubles as the occupancy count)
//   - default channel width and channel count
package pipe_pkg;

  localparam int PIPE_W   = 32;
  localparam int PIPE_NCH = 7;

  localparam int CH_CMD = 0;
  localparam int CH_PC  = 1;
  localparam int CH_DM  = 2;
  localparam int CH_ALU = 3;
  localparam int CH_HI  = 4;
  localparam int CH_LO  = 5;
  localparam int CH_CP0 = 6;

  // Encoding equals the number of occupied entries, so occ is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_slot_if.sv
// Interface pipe_stage_slot_if: valid/ready bus around one pipeline stage slot.
//   in_valid/in_ready/in_data : upstream beat handshake
//   flush                     : synchronous flush request into the slot
//   out_valid/out_ready/out_data : downstream beat handshake
//   occ                       : diagnostic occupancy 0..2
// Modports: master = the environment around the slot, slave = the slot itself.
interface pipe_stage_slot_if #(
  parameter int W   = pipe_pkg::PIPE_W,
  parameter int NCH = pipe_pkg::PIPE_NCH
);

  logic               in_valid;
  logic               in_ready;
  logic [NCH*W-1:0]   in_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [NCH*W-1:0]   out_data;
  logic [1:0]         occ;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, occ
  );

endinterface

// File: rtl/pipe_stage_slot_entry.sv
// Module pipe_entry: one NCH*W storage entry of the stage slot.
//   clk, res   : clock, asynchronous active-low reset (clears the entry)
//   i_load     : capture i_data
//   i_clear    : zero every channel except KEEP_CH (wins over i_load)
//   i_data     : data to capture
//   o_data     : current entry contents
// KEEP_CH >= NCH keeps no channel, i.e. i_clear zeroes the whole entry.
module pipe_entry #(
  parameter int W       = 32,
  parameter int NCH     = 7,
  parameter int KEEP_CH = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [NCH*W-1:0] i_data,
  output logic [NCH*W-1:0] o_data
);

  logic [NCH*W-1:0] r_data;
  logic [NCH*W-1:0] w_keepMask;

  // All-ones over the kept channel, zero elsewhere.
  for (genvar k = 0; k < NCH; k++) begin : g_mask
    assign w_keepMask[k*W +: W] = (k == KEEP_CH) ? {W{1'b1}} : {W{1'b0}};
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= r_data & w_keepMask;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_slot.sv
// Module pipe_stage_slot: one pipeline stage slot with valid/ready handshake,
// optional one-entry skid buffer and flush-to-bubble.
//   clk  : clock, rising edge
//   res  : asynchronous active-low reset
//   bus  : pipe_stage_slot_if.slave (in/out handshakes, flush, occ)
// SKID=1 : main + skid entries, in_ready is registered (state != TWO).
// SKID=0 : main entry only, in_ready = ~out_valid | out_ready (combinational).
// On flush the slot empties; the main entry keeps only channel KEEP_CH so the
// exception logic still sees the address of the bubble.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int W       = PIPE_W,
  parameter int NCH     = PIPE_NCH,
  parameter int SKID    = 1,
  parameter int KEEP_CH = CH_PC
) (
  input logic           clk,
  input logic           res,
  pipe_stage_slot_if.slave bus
);

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_inFire;
  logic             w_outFire;
  logic             w_outValid;
  logic             w_inReady;
  logic             w_mainLoad;
  logic             w_mainFromSkid;
  logic             w_skidLoad;
  logic [NCH*W-1:0] w_mainIn;
  logic [NCH*W-1:0] w_mainData;
  logic [NCH*W-1:0] w_skidData;

  assign w_outValid = (r_state != ST_EMPTY);
  assign w_inFire   = bus.in_valid & w_inReady;
  assign w_outFire  = w_outValid & bus.out_ready;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Flush is evaluated last so it overrides any load decided above it; a beat
  // accepted in the flush cycle is simply never stored.
  always_comb begin
    w_stateNext    = r_state;
    w_mainLoad     = 1'b0;
    w_mainFromSkid = 1'b0;
    w_skidLoad     = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_inFire) begin
          w_stateNext = ST_ONE;
          w_mainLoad  = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_inFire && w_outFire) begin
          w_mainLoad = 1'b1;
        end else if (w_inFire) begin
          if (SKID != 0) begin
            w_stateNext = ST_TWO;
            w_skidLoad  = 1'b1;
          end
        end else if (w_outFire) begin
          w_stateNext = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_outFire) begin
          w_stateNext    = ST_ONE;
          w_mainLoad     = 1'b1;
          w_mainFromSkid = 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_EMPTY;
      end
    endcase
    if (bus.flush) begin
      w_stateNext = ST_EMPTY;
      w_mainLoad  = 1'b0;
      w_skidLoad  = 1'b0;
    end
  end

  assign w_mainIn = w_mainFromSkid ? w_skidData : bus.in_data;

  pipe_entry #(.W(W), .NCH(NCH), .KEEP_CH(KEEP_CH)) u_main (
    .clk     (clk),
    .res     (res),
    .i_load  (w_mainLoad),
    .i_clear (bus.flush),
    .i_data  (w_mainIn),
    .o_data  (w_mainData)
  );

  if (SKID != 0) begin : g_skid
    // Skid entry keeps nothing on flush (KEEP_CH = NCH).
    pipe_entry #(.W(W), .NCH(NCH), .KEEP_CH(NCH)) u_skid (
      .clk     (clk),
      .res     (res),
      .i_load  (w_skidLoad),
      .i_clear (bus.flush),
      .i_data  (bus.in_data),
      .o_data  (w_skidData)
    );
    assign w_inReady = (r_state != ST_TWO);
  end else begin : g_noskid
    logic w_unusedSkidLoad;
    assign w_unusedSkidLoad = w_skidLoad;
    assign w_skidData       = '0;
    assign w_inReady        = ~w_outValid | bus.out_ready;
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_data  = w_mainData;
  assign bus.occ       = r_state;

endmodule

// File: tb/tb_pipe_stage_slot.sv
// Testbench tb_pipe_stage_slot: drives one SKID=1 slot (dut index 0) and one
// SKID=0 slot (dut index 1). A monitor keeps a queue-based reference per slot:
// accepted beats are pushed, consumed beats are popped and compared, and a
// flush empties the queue. Directed scenarios add point checks on top.
module tb_pipe_stage_slot;
  import pipe_pkg::*;

  localparam int W   = 32;
  localparam int NCH = 7;
  localparam int DW  = W * NCH;
  typedef logic [DW-1:0] beat_t;

  logic  clk;
  logic  res;
  int    errors = 0;
  int    checks = 0;
  beat_t q0[$];
  beat_t q1[$];
  beat_t shown0;
  beat_t shown1;
  beat_t keepMask;

  pipe_stage_slot_if #(.W(W), .NCH(NCH)) ifSkid ();
  pipe_stage_slot_if #(.W(W), .NCH(NCH)) ifNoSkid ();

  pipe_stage_slot #(.W(W), .NCH(NCH), .SKID(1), .KEEP_CH(CH_PC)) dutSkid (
    .clk (clk),
    .res (res),
    .bus (ifSkid)
  );

  pipe_stage_slot #(.W(W), .NCH(NCH), .SKID(0), .KEEP_CH(CH_PC)) dutNoSkid (
    .clk (clk),
    .res (res),
    .bus (ifNoSkid)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic beat_t rep(input logic [W-1:0] v);
    return {NCH{v}};
  endfunction

  function automatic beat_t chanSet(input beat_t b, input int ch, input logic [W-1:0] v);
    beat_t r;
    r = b;
    r[ch*W +: W] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] chanGet(input beat_t b, input int ch);
    return b[ch*W +: W];
  endfunction

  function automatic beat_t randBeat();
    beat_t r;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = $urandom();
    return r;
  endfunction

  task automatic checkVal(input string name, input int idx, input beat_t got, input beat_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s dut%0d got=%h want=%h", name, idx, got, want);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input beat_t d, input logic r, input logic f);
    if (idx == 0) begin
      ifSkid.in_valid  = v;
      ifSkid.in_data   = d;
      ifSkid.out_ready = r;
      ifSkid.flush     = f;
    end else begin
      ifNoSkid.in_valid  = v;
      ifNoSkid.in_data   = d;
      ifNoSkid.out_ready = r;
      ifNoSkid.flush     = f;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: the slot is a FIFO of depth 2 (SKID=1) or 1 (SKID=0); the
  // output shows the head, or the last shown value when empty (masked to the
  // PC channel after a flush).
  task automatic checkOutput(input int idx, input logic rst, input logic inValid,
                             input logic inReady, input beat_t inData, input logic flush,
                             input logic outValid, input logic outReady,
                             input beat_t outData, input logic [1:0] occ);
    beat_t q[$];
    beat_t shown;
    int    depth;
    logic  expReady;
    logic  inFire;
    logic  outFire;
    if (idx == 0) begin
      q = q0; shown = shown0;
    end else begin
      q = q1; shown = shown1;
    end
    if (!rst) begin
      q.delete();
      shown = '0;
    end else begin
      depth    = q.size();
      expReady = (idx == 0) ? (depth < 2) : (depth == 0 || outReady);
      checkVal("out_valid", idx, beat_t'(outValid), beat_t'(depth != 0));
      checkVal("occ", idx, beat_t'(occ), beat_t'(depth));
      checkVal("in_ready", idx, beat_t'(inReady), beat_t'(expReady));
      checkVal("out_data", idx, outData, shown);
      inFire  = inValid & expReady;
      outFire = (depth != 0) & outReady;
      if (outFire) void'(q.pop_front());
      if (flush) begin
        q.delete();
        shown = shown & keepMask;
      end else if (inFire) begin
        q.push_back(inData);
      end
      if (q.size() != 0) shown = q[0];
    end
    if (idx == 0) begin
      q0 = q; shown0 = shown;
    end else begin
      q1 = q; shown1 = shown;
    end
  endtask

  // Monitor samples on the falling edge, halfway between drive and capture.
  always @(negedge clk) begin
    checkOutput(0, res, ifSkid.in_valid, ifSkid.in_ready, ifSkid.in_data, ifSkid.flush,
                ifSkid.out_valid, ifSkid.out_ready, ifSkid.out_data, ifSkid.occ);
    checkOutput(1, res, ifNoSkid.in_valid, ifNoSkid.in_ready, ifNoSkid.in_data, ifNoSkid.flush,
                ifNoSkid.out_valid, ifNoSkid.out_ready, ifNoSkid.out_data, ifNoSkid.occ);
  end

  // Directed scenarios followed by a random run.
  initial begin
    beat_t fb;
    for (int k = 0; k < NCH; k++) keepMask[k*W +: W] = (k == CH_PC) ? '1 : '0;
    res = 1'b0;
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 res = 1'b1;

    // Streaming 0x100..0x10F through the skid slot.
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      checkVal("stream_in_ready", 0, beat_t'(ifSkid.in_ready), beat_t'(1));
      applyStimulus(0, 1'b1, rep(32'h100 + i), 1'b1, 1'b0);
    end
    nextCycle();
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();

    // Backpressure: A, B fill the slot, C waits until space opens.
    applyStimulus(0, 1'b1, rep(32'hA), 1'b0, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b1, rep(32'hB), 1'b0, 1'b0);
    nextCycle();
    checkVal("bp_occ_full", 0, beat_t'(ifSkid.occ), beat_t'(2));
    checkVal("bp_ready_low", 0, beat_t'(ifSkid.in_ready), beat_t'(0));
    applyStimulus(0, 1'b1, rep(32'hC), 1'b0, 1'b0);
    nextCycle();
    checkVal("bp_c_refused", 0, beat_t'(ifSkid.occ), beat_t'(2));
    checkVal("bp_head_a", 0, ifSkid.out_data, rep(32'hA));
    applyStimulus(0, 1'b1, rep(32'hC), 1'b1, 1'b0);
    nextCycle();
    checkVal("bp_head_b", 0, ifSkid.out_data, rep(32'hB));
    checkVal("bp_valid_b", 0, beat_t'(ifSkid.out_valid), beat_t'(1));
    applyStimulus(0, 1'b1, rep(32'hC), 1'b1, 1'b0);
    nextCycle();
    checkVal("bp_head_c", 0, ifSkid.out_data, rep(32'hC));
    checkVal("bp_valid_c", 0, beat_t'(ifSkid.out_valid), beat_t'(1));
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
    nextCycle();
    checkVal("bp_drained", 0, beat_t'(ifSkid.out_valid), beat_t'(0));

    // Flush keeping the PC channel while beat 0xD is accepted and dropped.
    fb = rep(32'h11111111);
    fb = chanSet(fb, CH_PC, 32'h00003000);
    fb = chanSet(fb, CH_CMD, 32'h8C010004);
    applyStimulus(0, 1'b1, fb, 1'b0, 1'b0);
    nextCycle();
    checkVal("flush_pre", 0, ifSkid.out_data, fb);
    applyStimulus(0, 1'b1, rep(32'hD), 1'b0, 1'b1);
    nextCycle();
    checkVal("flush_valid", 0, beat_t'(ifSkid.out_valid), beat_t'(0));
    checkVal("flush_occ", 0, beat_t'(ifSkid.occ), beat_t'(0));
    checkVal("flush_cmd", 0, beat_t'(chanGet(ifSkid.out_data, CH_CMD)), beat_t'(0));
    checkVal("flush_pc", 0, beat_t'(chanGet(ifSkid.out_data, CH_PC)), beat_t'(32'h00003000));
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkVal("flush_no_d", 0, beat_t'(ifSkid.out_valid), beat_t'(0));
    end

    // Single-entry slot: combinational in_ready and same-cycle replace.
    applyStimulus(1, 1'b1, rep(32'h55), 1'b0, 1'b0);
    nextCycle();
    checkVal("ns_full", 1, beat_t'(ifNoSkid.out_valid), beat_t'(1));
    applyStimulus(1, 1'b1, rep(32'h66), 1'b0, 1'b0);
    #1 checkVal("ns_ready_low", 1, beat_t'(ifNoSkid.in_ready), beat_t'(0));
    applyStimulus(1, 1'b1, rep(32'h66), 1'b1, 1'b0);
    #1 checkVal("ns_ready_high", 1, beat_t'(ifNoSkid.in_ready), beat_t'(1));
    nextCycle();
    checkVal("ns_replaced", 1, ifNoSkid.out_data, rep(32'h66));
    checkVal("ns_occ", 1, beat_t'(ifNoSkid.occ), beat_t'(1));
    applyStimulus(1, 1'b0, '0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();

    // Asynchronous reset with both skid entries full.
    applyStimulus(0, 1'b1, rep(32'h77), 1'b0, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b1, rep(32'h78), 1'b0, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0);
    #2 res = 1'b0;
    #1;
    checkVal("rst_valid", 0, beat_t'(ifSkid.out_valid), beat_t'(0));
    checkVal("rst_occ", 0, beat_t'(ifSkid.occ), beat_t'(0));
    checkVal("rst_data", 0, ifSkid.out_data, '0);
    checkVal("rst_ready", 0, beat_t'(ifSkid.in_ready), beat_t'(1));
    @(negedge clk);
    #1 res = 1'b1;

    // Random traffic on both slots.
    for (int i = 0; i < 600; i++) begin
      nextCycle();
      for (int d = 0; d < 2; d++) begin
        applyStimulus(d, $urandom_range(0, 99) < 70, randBeat(),
                      $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 6);
      end
    end
    nextCycle();
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, '0, 1'b1, 1'b0);
    repeat (4) nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
